// File: rtl/ps2_key_emitter.sv
// Keyboard-side PS/2 transmitter: one decimal digit in, one full keystroke
// (make, 0xF0, make) out on an emulated PS/2 clock/data pair.
module ps2_key_emitter #(
  parameter int HALF_PERIOD = 4000,
  parameter int GAP_CYCLES  = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_digit,
  input  logic       key_valid,
  output logic       key_ready,
  output logic       ps2_kb_clk,
  output logic       ps2_kb_data,
  output logic       key_err,
  output logic       key_done,
  output logic [1:0] dbg_state
);

  // Handshake: a request is taken on any edge where key_valid && key_ready;
  // key_ready is high only in IDLE, so requests while busy are simply dropped.

  localparam int CNT_MAX = (GAP_CYCLES > HALF_PERIOD) ? GAP_CYCLES : HALF_PERIOD;
  localparam int CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, SH_H, SH_L, GAP} state_t;

  state_t        state;
  logic [CW-1:0] phase;
  logic [3:0]    bit_idx;
  logic [1:0]    byte_idx;
  logic [7:0]    code;
  logic [7:0]    cur_byte;

  function automatic logic [7:0] make_code(input logic [3:0] d);
    logic [7:0] m;
    case (d)
      4'd0:    m = 8'h45;
      4'd1:    m = 8'h16;
      4'd2:    m = 8'h1E;
      4'd3:    m = 8'h26;
      4'd4:    m = 8'h25;
      4'd5:    m = 8'h2E;
      4'd6:    m = 8'h36;
      4'd7:    m = 8'h3D;
      4'd8:    m = 8'h3E;
      4'd9:    m = 8'h46;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  // Bit idx of an 11-bit frame: start, 8 data bits LSB first, odd parity, stop.
  function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
    logic       v;
    logic [2:0] sel;
    sel = 3'(idx - 4'd1);
    if (idx == 4'd0)
      v = 1'b0;
    else if (idx <= 4'd8)
      v = b[sel];
    else if (idx == 4'd9)
      v = ~^b;
    else
      v = 1'b1;
    return v;
  endfunction

  assign cur_byte  = (byte_idx == 2'd1) ? 8'hF0 : code;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      phase       <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      code        <= '0;
      key_ready   <= 1'b1;
      ps2_kb_clk  <= 1'b1;
      ps2_kb_data <= 1'b1;
      key_err     <= 1'b0;
      key_done    <= 1'b0;
    end else begin
      key_err  <= 1'b0;
      key_done <= 1'b0;
      case (state)
        IDLE: begin
          if (key_valid) begin
            if (key_digit <= 4'd9) begin
              code        <= make_code(key_digit);
              state       <= SH_H;
              phase       <= '0;
              bit_idx     <= '0;
              byte_idx    <= '0;
              key_ready   <= 1'b0;
              ps2_kb_clk  <= 1'b1;
              ps2_kb_data <= 1'b0;
            end else begin
              key_err <= 1'b1;
            end
          end
        end
        SH_H: begin
          if (phase == CW'(HALF_PERIOD - 1)) begin
            state      <= SH_L;
            phase      <= '0;
            ps2_kb_clk <= 1'b0;
          end else begin
            phase <= phase + CW'(1);
          end
        end
        SH_L: begin
          if (phase == CW'(HALF_PERIOD - 1)) begin
            phase      <= '0;
            ps2_kb_clk <= 1'b1;
            // Data only moves together with the rising PS/2 clock.
            if (bit_idx < 4'd10) begin
              state       <= SH_H;
              bit_idx     <= bit_idx + 4'd1;
              ps2_kb_data <= frame_bit(cur_byte, bit_idx + 4'd1);
            end else begin
              state       <= GAP;
              ps2_kb_data <= 1'b1;
            end
          end else begin
            phase <= phase + CW'(1);
          end
        end
        GAP: begin
          if (phase == CW'(GAP_CYCLES - 1)) begin
            phase <= '0;
            if (byte_idx < 2'd2) begin
              state       <= SH_H;
              byte_idx    <= byte_idx + 2'd1;
              bit_idx     <= '0;
              ps2_kb_clk  <= 1'b1;
              ps2_kb_data <= 1'b0;
            end else begin
              state     <= IDLE;
              key_ready <= 1'b1;
              key_done  <= 1'b1;
            end
          end else begin
            phase <= phase + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_key_emitter.sv
// Bench for ps2_key_emitter: a per-cycle waveform model built from the frame
// rules, a falling-edge PS/2 receiver, and literal frame/latency expectations.
module tb_ps2_key_emitter;

  localparam int HP  = 4;
  localparam int GAP = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_digit = 4'd0;
  logic       key_valid = 1'b0;
  logic       key_ready, ps2_kb_clk, ps2_kb_data, key_err, key_done;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  ps2_key_emitter #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .key_digit(key_digit), .key_valid(key_valid),
    .key_ready(key_ready), .ps2_kb_clk(ps2_kb_clk), .ps2_kb_data(ps2_kb_data),
    .key_err(key_err), .key_done(key_done), .dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // ---------------- model: expected {ready, clk, data, err, done} per cycle
  localparam logic [4:0] IDLE_V = 5'b11100;
  logic [4:0]  exp_q[$];
  logic [4:0]  cur = IDLE_V;
  int          cyc = 0;
  int          acc_cyc = 0;
  int          acc_cnt = 0;

  function automatic logic [7:0] make_of(input logic [3:0] d);
    logic [7:0] t [10];
    t = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    return t[d];
  endfunction

  task automatic push_keystroke(input logic [3:0] d);
    logic [7:0]  b;
    logic [10:0] bits;
    for (int f = 0; f < 3; f++) begin
      b = (f == 1) ? 8'hF0 : make_of(d);
      bits = {1'b1, ($countones(b) % 2 == 0), b, 1'b0};
      for (int i = 0; i < 11; i++) begin
        repeat (HP) exp_q.push_back({1'b0, 1'b1, bits[i], 2'b00});
        repeat (HP) exp_q.push_back({1'b0, 1'b0, bits[i], 2'b00});
      end
      repeat (GAP) exp_q.push_back(5'b01100);
    end
    exp_q.push_back(5'b11101);
  endtask

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      exp_q.delete();
      cur = IDLE_V;
    end else begin
      if (cur[4] && key_valid) begin
        if (key_digit <= 4'd9) begin
          push_keystroke(key_digit);
          acc_cyc = cyc;
          acc_cnt++;
        end else begin
          exp_q.push_back(5'b11110);
        end
      end
      if (exp_q.size() > 0) cur = exp_q.pop_front();
      else cur = IDLE_V;
    end
  end

  // ---------------- scoreboard compare + loop-back receiver
  logic [10:0] rx_q[$];
  logic [10:0] rx_sh = '0;
  int          rx_cnt = 0;
  logic        prev_kclk = 1'b1;
  int          err_cnt = 0;
  int          done_cnt = 0;
  logic [4:0]  act;

  always @(posedge clk) begin
    #1;
    act = {key_ready, ps2_kb_clk, ps2_kb_data, key_err, key_done};
    checks++;
    if (act !== cur) begin
      errors++;
      $display("FAIL cycle_%0d outputs rdy/clk/dat/err/done got %b want %b", cyc, act, cur);
    end
    if (key_err) err_cnt++;
    if (key_done) done_cnt++;
    if (!rst) begin
      rx_cnt = 0;
    end else if (prev_kclk && !ps2_kb_clk) begin
      rx_sh[rx_cnt] = ps2_kb_data;
      rx_cnt++;
      if (rx_cnt == 11) begin
        rx_q.push_back(rx_sh);
        rx_cnt = 0;
      end
    end
    prev_kclk = ps2_kb_clk;
  end

  // ---------------- driver tasks
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  task automatic send(input logic [3:0] d);
    @(negedge clk);
    key_digit = d;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, output int done_at);
    int n = 0;
    while (!key_done && n < 400) begin
      @(negedge clk);
      n++;
    end
    done_at = cyc;
    check({name, " done_seen"}, key_done, 1'b1);
  endtask

  task automatic check_frames(input string name, input logic [7:0] mk, input logic par);
    check({name, " frame_count"}, rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      check({name, " frame0"}, rx_q[0], {1'b1, par, mk, 1'b0});
      check({name, " frame1"}, rx_q[1], {1'b1, 1'b1, 8'hF0, 1'b0});
      check({name, " frame2"}, rx_q[2], {1'b1, par, mk, 1'b0});
    end
  endtask

  function automatic logic [3:0] decode(input logic [7:0] sc);
    logic [3:0] d;
    case (sc)
      8'h45: d = 4'd0; 8'h16: d = 4'd1; 8'h1E: d = 4'd2; 8'h26: d = 4'd3;
      8'h25: d = 4'd4; 8'h2E: d = 4'd5; 8'h36: d = 4'd6; 8'h3D: d = 4'd7;
      8'h3E: d = 4'd8; 8'h46: d = 4'd9; default: d = 4'hF;
    endcase
    return d;
  endfunction

  int done_at;
  int e0;
  int d0;
  int a0;

  initial begin
    // reset held with a request present: the request must be discarded
    key_valid = 1'b1;
    key_digit = 4'd3;
    repeat (3) @(negedge clk);
    check("reset outputs", {key_ready, ps2_kb_clk, ps2_kb_data, key_err, key_done}, 5'b11100);
    rst = 1'b1;
    key_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("reset no_tx", rx_q.size(), 0);
    check("reset no_accept", acc_cnt, 0);

    // digit 0: frame contents and keystroke latency
    rx_q.delete();
    send(4'd0);
    wait_done("d0", done_at);
    check("d0 latency_edges", done_at - acc_cyc, 288);
    check("d0 ready_with_done", key_ready, 1'b1);
    check_frames("d0", 8'h45, 1'b0);
    if (rx_q.size() == 3) check("d0 decode", decode(rx_q[0][8:1]), 4'd0);

    // digits 1 and 9
    rx_q.delete();
    send(4'd1);
    wait_done("d1", done_at);
    check_frames("d1", 8'h16, 1'b0);
    rx_q.delete();
    send(4'd9);
    wait_done("d9", done_at);
    check_frames("d9", 8'h46, 1'b0);
    if (rx_q.size() == 3) check("d9 decode", decode(rx_q[2][8:1]), 4'd9);

    // invalid digit, then a valid request on the very next cycle
    rx_q.delete();
    e0 = err_cnt;
    a0 = acc_cnt;
    @(negedge clk);
    key_digit = 4'hC;
    key_valid = 1'b1;
    @(negedge clk);
    check("inv err_pulse", key_err, 1'b1);
    check("inv ready", key_ready, 1'b1);
    key_digit = 4'd7;
    @(negedge clk);
    key_valid = 1'b0;
    check("inv err_once", err_cnt - e0, 1);
    check("inv next_accepted", acc_cnt - a0, 1);
    wait_done("d7", done_at);
    check_frames("d7", 8'h3D, 1'b0);

    // busy requests: valid held through a keystroke
    rx_q.delete();
    a0 = acc_cnt;
    @(negedge clk);
    key_digit = 4'd5;
    key_valid = 1'b1;
    wait_done("busy1", done_at);
    check("busy one_accept", acc_cnt - a0, 1);
    @(negedge clk);
    key_valid = 1'b0;
    check("busy second_on_done", acc_cnt - a0, 2);
    wait_done("busy2", done_at);
    check("busy frames", rx_q.size(), 6);
    if (rx_q.size() == 6) begin
      check("busy frame0", rx_q[0], {1'b1, 1'b1, 8'h2E, 1'b0});
      check("busy frame4", rx_q[4], {1'b1, 1'b1, 8'hF0, 1'b0});
      check("busy frame5", rx_q[5], {1'b1, 1'b1, 8'h2E, 1'b0});
    end

    // reset during frame 1, bit 4
    rx_q.delete();
    d0 = done_cnt;
    send(4'd2);
    repeat (128) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrst outputs", {key_ready, ps2_kb_clk, ps2_kb_data, key_err, key_done}, 5'b11100);
    repeat (300) @(negedge clk);
    check("midrst no_done", done_cnt - d0, 0);
    check("midrst frames", rx_q.size(), 1);
    rx_q.delete();
    send(4'd4);
    wait_done("d4", done_at);
    check_frames("d4", 8'h25, 1'b0);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_key_emitter.md
# ps2_key_emitter

Keyboard-side PS/2 transmitter: takes a 4-bit decimal digit, translates it to its Set-2 scan code and serialises it as a full keystroke (make code, 0xF0, make code) on a PS/2 clock/data pair. It is the device-end counterpart of the keyboard receive path and its scan-code-to-binary conversion. It drives the receive path in loop-back tests and on the board's emulated-keyboard header.

## Interface
- HALF_PERIOD, 4000: system clocks per PS/2 clock half period. 12.5 kHz PS/2 clock at 100 MHz. Legal range is 2 or more.
- GAP_CYCLES, 20000: idle system clocks after each frame, with both lines high. Legal range is 1 or more.

- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  synchronous reset, active low
- key_digit  in  4  digit to send
- key_valid  in  1  request; qualifies key_digit
- key_ready  out  1  high only in IDLE; the request is accepted on a cycle with key_valid && key_ready
- ps2_kb_clk  out  1  emitted PS/2 clock; idles high
- ps2_kb_data  out  1  emitted PS/2 data; idles high
- key_err  out  1  one-cycle pulse when the accepted digit is greater than 9
- key_done  out  1  one-cycle pulse when the keystroke is complete

## Operation
- **Digit map.** Each digit translates to its Set-2 make code:
  - 0→0x45, 1→0x16, 2→0x1E, 3→0x26, 4→0x25
  - 5→0x2E, 6→0x36, 7→0x3D, 8→0x3E, 9→0x46
  - 10–15 are invalid.
- **Invalid digit.** The request is consumed and key_err pulses on the next cycle. Nothing is transmitted, the block stays in IDLE, and key_ready remains high.
- **Keystroke.** A valid digit is latched at acceptance, then three frames are sent in order: make, 0xF0, make. Index byte_idx runs 0..2.
- **Frame.** 11 bits: start 0, data[0]..data[7] (LSB first), odd parity (= ~^data), stop 1.
- **Bit slot.** Each bit occupies 2×HALF_PERIOD cycles:
  - H phase, HALF_PERIOD cycles: ps2_kb_clk=1, ps2_kb_data=bit.
  - L phase, HALF_PERIOD cycles: ps2_kb_clk=0, ps2_kb_data holds bit.
  - Data changes only at the start of an H phase, so it is stable across every falling edge.
- **States:**
  - IDLE: lines high, key_ready=1. A valid request goes to SH_H with bit_idx=0 and byte_idx=0. An invalid one stays in IDLE.
  - SH_H: goes to SH_L when the phase counter reaches HALF_PERIOD-1.
  - SH_L: at HALF_PERIOD-1, goes to SH_H with bit_idx+1 if bit_idx<10, else to GAP.
  - GAP: lines high. After GAP_CYCLES cycles, goes to SH_H with byte_idx+1 and bit_idx=0 if byte_idx<2. Otherwise goes to IDLE and pulses key_done.
- **Ignored inputs.** key_valid outside IDLE is ignored; no queueing. key_digit is sampled only at acceptance.
- **Counters.** The phase counter resets to 0 on every state change. bit_idx is 4 bits (0..10) and byte_idx is 2 bits (0..2); neither wraps past its maximum.

## Timing
- **Reset values:** key_ready=1, ps2_kb_clk=1, ps2_kb_data=1, key_err=0, key_done=0, state IDLE.
- **Reset mid-keystroke:** rst low at any point aborts the keystroke. All outputs take their reset values at that edge; no partial frame resumes.
- **Registered outputs:** all outputs are registered; no combinational path from inputs to outputs.
- **First bit:** acceptance happens at edge T. From T+1, key_ready=0 and ps2_kb_data=0 (start bit) with ps2_kb_clk=1.
- **First falling PS/2 clock edge:** at T+1+HALF_PERIOD.
- **Frame length:** 22×HALF_PERIOD cycles, followed by GAP_CYCLES idle cycles.
- **Keystroke latency:** key_done is high for exactly one cycle at T+1+3×(22×HALF_PERIOD+GAP_CYCLES), with key_ready=1 in the same cycle. A new request can be accepted in that cycle.
- **key_err:** high at T+1 only.
- **Simultaneous events:** a request arriving in the same cycle as rst low is discarded.

## Test plan
All scenarios use HALF_PERIOD=4 and GAP_CYCLES=8, giving a 96-cycle frame slot and a 288-cycle keystroke.
- **Reset:** hold rst low for 3 cycles with key_valid=1 → lines high, key_ready=1, no key_err or key_done, and no transmission after release until a new request.
- **Digit 0:** request at T → three frames.
  - Frame 0, 0x45: bits sampled on falling edges are 0, 1,0,1,0,0,0,1,0, parity 0, stop 1.
  - Frame 1, 0xF0: parity 1.
  - Frame 2: repeats 0x45.
  - key_done at T+289; a loop-back receive path decodes 4'b0000.
- **Digit 1 (0x16, parity 0) and digit 9 (0x46, parity 0):** data never changes while ps2_kb_clk=0, and the gap between frames is exactly 8 idle cycles.
- **Invalid digit 4'hC:**
  - key_err high at T+1 only; the lines never leave 1; key_ready stays 1.
  - A valid request at T+2 is accepted.
- **Busy requests:** hold key_valid high with digit 5 throughout one keystroke → exactly one keystroke of 0x2E, 0xF0, 0x2E per acceptance. A second keystroke starts on the key_done cycle.
- **Reset mid-keystroke:** assert rst low during frame 1, bit 4 → lines high and key_ready=1 on the next edge, no key_done, and a fresh request produces a complete keystroke.
